// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmitter. It sends one word per frame: a start bit, the data bits
//   LSB first, an optional parity bit, then one or two stop bits. The baud
//   rate is set by a fixed clocks-per-bit divider. A valid/ready handshake lets
//   an upstream FIFO or sequencer stream words into the block.
//
// Ports
//   clk      system clock; all logic runs on the rising edge
//   i_reset  asynchronous active-high reset
//   i_data   word to transmit, sampled only on an accept cycle
//   i_valid  producer has a word on i_data
//   o_ready  block can accept a word (high only in IDLE)
//   o_tx     registered serial line; idles high
//   o_busy   a frame is in progress
//   o_done   one-cycle pulse on the last cycle of the final stop bit
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  baud_end;
    logic                  done;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done     = 1'b0;
        baud_end = (baud_q == BAUD_LAST);

        // The baud counter free-runs through every non-idle state and wraps on
        // the terminal count, which is also where bits and states advance.
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    shift_d  = i_data;
                    parity_d = (PARITY == 1) ? ~^i_data : ^i_data;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // The bit counter is reused to count stop bits.
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The line value is decoded from the next state and next shift value,
        // so the registered o_tx lines up exactly with the state it belongs to.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
    end

    assign o_tx    = tx_q;
    assign o_ready = (state_q == S_IDLE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_done  = done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame. Four instances share one clock and one reset
// and use different frame formats:
//   0: 8 data bits, no parity, 1 stop bit
//   1: 8 data bits, even parity, 1 stop bit
//   2: 8 data bits, odd parity, 1 stop bit
//   3: 7 data bits, no parity, 2 stop bits
// All instances run at 4 clocks per bit. When a test drives a word, it also
// pushes the expected per-cycle outputs into a queue. The observed outputs
// are collected at negedges and then compared against that queue.
module tb_uart_tx_frame;

    typedef struct packed {
        logic tx;
        logic done;
        logic busy;
        logic ready;
    } cyc_t;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic [3:0] valid_r;
    logic [8:0] data_r [4];
    logic [3:0] tx_w, done_w, busy_w, ready_w;

    int nb_m [4] = '{8, 8, 8, 7};
    int par_m[4] = '{0, 2, 1, 0};
    int st_m [4] = '{1, 1, 1, 2};

    cyc_t exp_q[$];
    cyc_t obs_q[$];

    int tests;
    int fails;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_plain (
        .clk(clk), .i_reset(reset), .i_data(data_r[0][7:0]), .i_valid(valid_r[0]),
        .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .i_reset(reset), .i_data(data_r[1][7:0]), .i_valid(valid_r[1]),
        .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .i_reset(reset), .i_data(data_r[2][7:0]), .i_valid(valid_r[2]),
        .o_ready(ready_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_seven (
        .clk(clk), .i_reset(reset), .i_data(data_r[3][6:0]), .i_valid(valid_r[3]),
        .o_ready(ready_w[3]), .o_tx(tx_w[3]), .o_busy(busy_w[3]), .o_done(done_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one whole frame, followed by the single idle cycle
    // that comes after it.
    task automatic push_frame(input int idx, input logic [8:0] word);
        logic bits[$];
        logic p;
        int   n;
        bits.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < nb_m[idx]; i++) begin
            bits.push_back(word[i]);
            p = p ^ word[i];
        end
        if (par_m[idx] != 0) begin
            bits.push_back(par_m[idx] == 1 ? ~p : p);
        end
        for (int i = 0; i < st_m[idx]; i++) begin
            bits.push_back(1'b1);
        end
        n = bits.size() * CPB;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{tx: bits[k / CPB], done: (k == n - 1), busy: 1'b1, ready: 1'b0});
        end
        exp_q.push_back('{tx: 1'b1, done: 1'b0, busy: 1'b0, ready: 1'b1});
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{tx: 1'b1, done: 1'b0, busy: 1'b0, ready: 1'b1});
        end
    endtask

    // Presents one word for exactly one rising edge while the instance is idle.
    task automatic applyStimulus(input int idx, input logic [8:0] word);
        @(negedge clk);
        valid_r[idx] = 1'b1;
        data_r[idx]  = word;
        @(posedge clk);
        #1;
        valid_r[idx] = 1'b0;
    endtask

    task automatic capture(input int idx, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            obs_q.push_back({tx_w[idx], done_w[idx], busy_w[idx], ready_w[idx]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({tx_w[i], done_w[i], busy_w[i], ready_w[i]} !== 4'b1001) begin
                fails++;
                $display("[TB] FAIL reset_during inst %0d: tx/done/busy/ready got %b want 1001",
                         i, {tx_w[i], done_w[i], busy_w[i], ready_w[i]});
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({tx_w[i], done_w[i], busy_w[i], ready_w[i]} !== 4'b1001) begin
                fails++;
                $display("[TB] FAIL reset_after inst %0d: tx/done/busy/ready got %b want 1001",
                         i, {tx_w[i], done_w[i], busy_w[i], ready_w[i]});
            end
        end
    endtask

    task automatic test_frame_formats();
        int          idx_t [5] = '{0, 1, 2, 1, 3};
        logic [8:0]  word_t[5] = '{9'h0AA, 9'h0AA, 9'h0AA, 9'h007, 9'h055};
        for (int t = 0; t < 5; t++) begin
            int c;
            exp_q.delete();
            obs_q.delete();
            push_frame(idx_t[t], word_t[t]);
            applyStimulus(idx_t[t], word_t[t]);
            capture(idx_t[t], exp_q.size());
            c = 0;
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                cyc_t e = exp_q.pop_front();
                cyc_t o = obs_q.pop_front();
                c++;
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL format%0d inst %0d word %h cycle %0d: tx/done/busy/ready got %b want %b",
                             t, idx_t[t], word_t[t], c, o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int done_cnt;
        exp_q.delete();
        obs_q.delete();
        push_frame(0, 9'h001);
        push_frame(0, 9'h080);
        @(negedge clk);
        valid_r[0] = 1'b1;
        data_r[0]  = 9'h001;
        @(posedge clk);
        #1;
        data_r[0] = 9'h080;
        fork
            capture(0, exp_q.size());
            begin
                // The second accept happens on the edge that closes the idle cycle.
                repeat (10 * CPB + 1) @(posedge clk);
                #1;
                valid_r[0] = 1'b0;
            end
        join
        done_cnt = 0;
        foreach (obs_q[k]) begin
            if (obs_q[k].done === 1'b1) done_cnt++;
        end
        tests++;
        if (done_cnt != 2) begin
            fails++;
            $display("[TB] FAIL b2b_done_count: got %0d pulses want 2", done_cnt);
        end
        c = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            cyc_t e = exp_q.pop_front();
            cyc_t o = obs_q.pop_front();
            c++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL b2b cycle %0d: tx/done/busy/ready got %b want %b", c, o, e);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int c;
        exp_q.delete();
        obs_q.delete();
        push_frame(0, 9'h03C);
        push_idle(2 * 10 * CPB);
        applyStimulus(0, 9'h03C);
        fork
            capture(0, exp_q.size());
            begin
                repeat (12) @(negedge clk);
                valid_r[0] = 1'b1;
                data_r[0]  = 9'h0FF;
                @(negedge clk);
                valid_r[0] = 1'b0;
            end
        join
        c = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            cyc_t e = exp_q.pop_front();
            cyc_t o = obs_q.pop_front();
            c++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL ignore_busy cycle %0d: tx/done/busy/ready got %b want %b", c, o, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        int c;
        exp_q.delete();
        obs_q.delete();
        // Only the first 10 cycles of this frame are observed before the abort.
        push_frame(0, 9'h03C);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        applyStimulus(0, 9'h03C);
        capture(0, 10);
        reset = 1'b1;
        #1;
        tests++;
        if ({tx_w[0], done_w[0], busy_w[0], ready_w[0]} !== 4'b1001) begin
            fails++;
            $display("[TB] FAIL mid_reset_immediate: tx/done/busy/ready got %b want 1001",
                     {tx_w[0], done_w[0], busy_w[0], ready_w[0]});
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_idle(5);
        capture(0, 5);
        push_frame(0, 9'h05A);
        applyStimulus(0, 9'h05A);
        capture(0, 10 * CPB + 1);
        c = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            cyc_t e = exp_q.pop_front();
            cyc_t o = obs_q.pop_front();
            c++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL mid_reset cycle %0d: tx/done/busy/ready got %b want %b", c, o, e);
            end
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        valid_r = '0;
        for (int i = 0; i < 4; i++) data_r[i] = '0;

        test_reset();
        test_frame_formats();
        test_back_to_back();
        test_ignore_busy();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
